// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types for the UART blocks: parity mode selection and the
//             transmit FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo
//  Purpose  : Synchronous show-ahead FIFO. rd_data always presents the oldest
//             word; pop consumes it. Pushes while full and pops while empty
//             are ignored.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             push, wr_data       - write request and word
//             pop, rd_data        - read request and head-of-queue word
//             full, empty, count  - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == c_cw'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rd_data   = r_mem[r_rd_ptr];
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   // Storage carries no reset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : UART transmitter with a transmit FIFO. Words are queued with a
//             valid/ready handshake and sent as start, data (LSB first),
//             optional parity and stop bits on a registered, idle-high line.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             baud_div     - clk cycles per baud tick (0 behaves as 1)
//             valid_in     - data_in holds a word to queue
//             data_in      - word to transmit
//             ready_out    - FIFO not full
//             tx           - serial output
//             busy         - frame in progress or words queued
//             fifo_count   - words held in the FIFO
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int      DATA_BITS  = 8,
   parameter int      STOP_BITS  = 1,
   parameter parity_t PARITY     = PARITY_NONE,
   parameter int      OVERSAMPLE = 16,
   parameter int      DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [15:0]                baud_div,
   input  logic                       valid_in,
   input  logic [DATA_BITS-1:0]       data_in,
   output logic                       ready_out,
   output logic                       tx,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int c_tick_w = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int c_bit_w  = 4;
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
   localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_BITS - 1);
   localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);

   tx_state_t             r_state;
   tx_state_t             w_state_next;
   logic [15:0]           r_div;
   logic [15:0]           r_div_cnt;
   logic [c_tick_w-1:0]   r_tick_cnt;
   logic [c_bit_w-1:0]    r_bit_cnt;
   logic [DATA_BITS-1:0]  r_shreg;
   logic                  r_par_bit;
   logic                  r_tx;

   logic [15:0]           w_div_eff;
   logic                  w_tick;
   logic                  w_bit_end;
   logic                  w_pop;
   logic                  w_restart;
   logic                  w_shift;
   logic                  w_bit_inc;
   logic                  w_bit_clr;
   logic                  w_full;
   logic                  w_empty;
   logic [DATA_BITS-1:0]  w_fifo_data;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (valid_in),
      .wr_data (data_in),
      .pop     (w_pop),
      .rd_data (w_fifo_data),
      .full    (w_full),
      .empty   (w_empty),
      .count   (fifo_count)
   );

   assign ready_out = ~w_full;
   assign tx        = r_tx;
   assign busy      = (r_state != TX_IDLE) || (fifo_count != '0);

   // The divisor in use is latched only at tick boundaries (and frame start),
   // so a baud_div change never cuts a tick short.
   assign w_div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
   assign w_tick    = (r_div_cnt == r_div - 16'd1);
   assign w_bit_end = w_tick && (r_tick_cnt == c_tick_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= TX_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_restart    = 1'b0;
      w_shift      = 1'b0;
      w_bit_inc    = 1'b0;
      w_bit_clr    = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_restart    = 1'b1;
               w_state_next = TX_START;
            end
         end
         TX_START: begin
            if (w_bit_end) begin
               w_bit_clr    = 1'b1;
               w_state_next = TX_DATA;
            end
         end
         TX_DATA: begin
            if (w_bit_end) begin
               w_shift = 1'b1;
               if (r_bit_cnt == c_data_last) begin
                  w_bit_clr    = 1'b1;
                  w_state_next = (PARITY == PARITY_NONE) ? TX_STOP : TX_PARITY;
               end else begin
                  w_bit_inc = 1'b1;
               end
            end
         end
         TX_PARITY: begin
            if (w_bit_end) begin
               w_bit_clr    = 1'b1;
               w_state_next = TX_STOP;
            end
         end
         TX_STOP: begin
            if (w_bit_end) begin
               if (r_bit_cnt == c_stop_last) begin
                  w_bit_clr = 1'b1;
                  // Chain straight into the next frame when words are queued.
                  if (!w_empty) begin
                     w_pop        = 1'b1;
                     w_restart    = 1'b1;
                     w_state_next = TX_START;
                  end else begin
                     w_state_next = TX_IDLE;
                  end
               end else begin
                  w_bit_inc = 1'b1;
               end
            end
         end
         default: w_state_next = TX_IDLE;
      endcase
   end

   // Baud tick and oversample counters. Restarting at START entry guarantees
   // a full-length start bit regardless of where the divider was.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div      <= 16'd1;
         r_div_cnt  <= '0;
         r_tick_cnt <= '0;
      end else if (w_restart) begin
         r_div      <= w_div_eff;
         r_div_cnt  <= '0;
         r_tick_cnt <= '0;
      end else if (r_state != TX_IDLE) begin
         if (w_tick) begin
            r_div      <= w_div_eff;
            r_div_cnt  <= '0;
            r_tick_cnt <= (r_tick_cnt == c_tick_last) ? '0 : r_tick_cnt + c_tick_w'(1);
         end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
         end
      end
   end

   // Shift register, bit counter and precomputed parity.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg   <= '0;
         r_par_bit <= 1'b0;
         r_bit_cnt <= '0;
      end else begin
         if (w_pop) begin
            r_shreg   <= w_fifo_data;
            r_par_bit <= (^w_fifo_data) ^ (PARITY == PARITY_ODD);
         end else if (w_shift) begin
            r_shreg <= r_shreg >> 1;
         end
         if (w_bit_clr) begin
            r_bit_cnt <= '0;
         end else if (w_bit_inc) begin
            r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
         end
      end
   end

   // The line is registered from the current state, so each bit appears on
   // tx one edge after the FSM enters it and keeps its exact length.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx <= 1'b1;
      end else begin
         case (r_state)
            TX_START:  r_tx <= 1'b0;
            TX_DATA:   r_tx <= r_shreg[0];
            TX_PARITY: r_tx <= r_par_bit;
            default:   r_tx <= 1'b1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_buffered
//  Purpose  : Self-checking bench for uart_tx_buffered. Four instances cover
//             8N1, 8E1, 8O1 and 7N2; expected line waveforms are built from
//             the frame format, and a random run decodes frames against a
//             queue of accepted words.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] baud_div = 16'd1;
   logic [3:0]  valid = '0;
   logic [7:0]  din [4];
   logic [3:0]  ready;
   logic [3:0]  txl;
   logic [3:0]  busy;
   logic [2:0]  cnt [4];

   int checks = 0;
   int errors = 0;

   bit         exp_wave [$];
   logic [7:0] wq [8];
   logic       tx_log   [1024];
   logic       busy_log [1024];
   logic       rdy_log  [1024];
   logic [2:0] cnt_log  [1024];

   always #5 clk = ~clk;

   uart_tx_buffered #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_NONE), .OVERSAMPLE(16), .DEPTH(4)) u_n1 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .valid_in(valid[0]), .data_in(din[0]),
      .ready_out(ready[0]), .tx(txl[0]), .busy(busy[0]), .fifo_count(cnt[0]));
   uart_tx_buffered #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_EVEN), .OVERSAMPLE(16), .DEPTH(4)) u_e1 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .valid_in(valid[1]), .data_in(din[1]),
      .ready_out(ready[1]), .tx(txl[1]), .busy(busy[1]), .fifo_count(cnt[1]));
   uart_tx_buffered #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_ODD), .OVERSAMPLE(16), .DEPTH(4)) u_o1 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .valid_in(valid[2]), .data_in(din[2]),
      .ready_out(ready[2]), .tx(txl[2]), .busy(busy[2]), .fifo_count(cnt[2]));
   uart_tx_buffered #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(PARITY_NONE), .OVERSAMPLE(16), .DEPTH(4)) u_n2 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .valid_in(valid[3]), .data_in(din[3][6:0]),
      .ready_out(ready[3]), .tx(txl[3]), .busy(busy[3]), .fifo_count(cnt[3]));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_all();
      rst   = 1'b1;
      valid = '0;
      step();
      step();
      rst = 1'b0;
      exp_wave.delete();
   endtask

   // Reference frame: start 0, data LSB first, optional parity, stop 1s,
   // each bit held for 'period' clk cycles.
   task automatic add_frame(input logic [7:0] w, input int nb, input int par, input int ns,
                            input int period);
      bit bits [$];
      bit p = 1'b0;
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         bits.push_back(w[i]);
         p = p ^ w[i];
      end
      if (par != 0) bits.push_back((par == 2) ? ~p : p);
      for (int i = 0; i < ns; i++) bits.push_back(1'b1);
      foreach (bits[k]) begin
         for (int j = 0; j < period; j++) exp_wave.push_back(bits[k]);
      end
   endtask

   // Presents wq[0..nwords-1] on consecutive cycles and logs outputs.
   task automatic drive_and_watch(input int idx, input int nwords, input int nsteps);
      for (int c = 0; c < nsteps; c++) begin
         if (c < nwords) begin
            valid[idx] = 1'b1;
            din[idx]   = wq[c];
         end else begin
            valid[idx] = 1'b0;
         end
         rdy_log[c] = ready[idx];
         step();
         tx_log[c]   = txl[idx];
         busy_log[c] = busy[idx];
         cnt_log[c]  = cnt[idx];
      end
      valid[idx] = 1'b0;
   endtask

   // First edge index whose tx differs from the reference (tx low from
   // edge 2 after the first accept), or -1.
   function automatic int first_mismatch(input int nsteps);
      bit e;
      for (int c = 0; c < nsteps; c++) begin
         e = (c >= 2 && (c - 2) < exp_wave.size()) ? exp_wave[c-2] : 1'b1;
         if (tx_log[c] !== e) return c;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (txl[i] !== 1'b1) begin errors++; $display("FAIL reset_tx[%0d] got %b want 1", i, txl[i]); end
         checks++;
         if (cnt[i] !== 3'd0) begin errors++; $display("FAIL reset_count[%0d] got %0d want 0", i, cnt[i]); end
         checks++;
         if (ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got %b want 1", i, ready[i]); end
         checks++;
         if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", i, busy[i]); end
      end
      rst = 1'b0;
   endtask

   task automatic test_8n1(input logic [15:0] bd, input string nm);
      int m;
      reset_all();
      baud_div = bd;
      wq[0] = 8'h55;
      add_frame(8'h55, 8, 0, 1, 16);
      drive_and_watch(0, 1, 170);
      checks++;
      if (cnt_log[0] !== 3'd1) begin errors++; $display("FAIL %s count_after_accept got %0d want 1", nm, cnt_log[0]); end
      checks++;
      if (tx_log[1] !== 1'b1) begin errors++; $display("FAIL %s tx_edge1 got %b want 1", nm, tx_log[1]); end
      checks++;
      if (tx_log[2] !== 1'b0) begin errors++; $display("FAIL %s tx_edge2 got %b want 0", nm, tx_log[2]); end
      m = first_mismatch(170);
      checks++;
      if (m !== -1) begin errors++; $display("FAIL %s waveform at edge %0d got %b want %b", nm, m, tx_log[m], ~tx_log[m]); end
      checks++;
      if (busy_log[160] !== 1'b1 || busy_log[161] !== 1'b0)
         begin errors++; $display("FAIL %s busy_end got %b%b want 10", nm, busy_log[160], busy_log[161]); end
   endtask

   task automatic test_parity(input int idx, input int par, input bit pexp, input string nm);
      int m;
      reset_all();
      baud_div = 16'd1;
      wq[0] = 8'hA3;
      add_frame(8'hA3, 8, par, 1, 16);
      drive_and_watch(idx, 1, 190);
      checks++;
      if (tx_log[2 + 9*16 + 8] !== pexp)
         begin errors++; $display("FAIL %s parity_bit got %b want %b", nm, tx_log[2 + 9*16 + 8], pexp); end
      m = first_mismatch(190);
      checks++;
      if (m !== -1) begin errors++; $display("FAIL %s waveform at edge %0d got %b want %b", nm, m, tx_log[m], ~tx_log[m]); end
      checks++;
      if (busy_log[176] !== 1'b1 || busy_log[177] !== 1'b0)
         begin errors++; $display("FAIL %s frame_len busy got %b%b want 10", nm, busy_log[176], busy_log[177]); end
   endtask

   task automatic test_7n2();
      int m;
      reset_all();
      baud_div = 16'd3;
      wq[0] = 8'h7F;
      add_frame(8'h7F, 7, 0, 2, 48);
      drive_and_watch(3, 1, 495);
      checks++;
      if (tx_log[2] !== 1'b0 || tx_log[2+47] !== 1'b0 || tx_log[2+48] !== 1'b1)
         begin errors++; $display("FAIL 7n2_start_len got %b%b%b want 001", tx_log[2], tx_log[49], tx_log[50]); end
      m = first_mismatch(495);
      checks++;
      if (m !== -1) begin errors++; $display("FAIL 7n2 waveform at edge %0d got %b want %b", m, tx_log[m], ~tx_log[m]); end
      checks++;
      if (busy_log[480] !== 1'b1 || busy_log[481] !== 1'b0)
         begin errors++; $display("FAIL 7n2 busy_end got %b%b want 10", busy_log[480], busy_log[481]); end
   endtask

   task automatic test_fifo_full();
      logic       rdy_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0] cnt_exp [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      int m;
      reset_all();
      baud_div = 16'd1;
      for (int i = 0; i < 6; i++) wq[i] = 8'(i + 1);
      for (int i = 0; i < 5; i++) add_frame(8'(i + 1), 8, 0, 1, 16);
      drive_and_watch(0, 6, 820);
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (rdy_log[c] !== rdy_exp[c]) begin errors++; $display("FAIL fifo_ready[%0d] got %b want %b", c, rdy_log[c], rdy_exp[c]); end
         checks++;
         if (cnt_log[c] !== cnt_exp[c]) begin errors++; $display("FAIL fifo_count[%0d] got %0d want %0d", c, cnt_log[c], cnt_exp[c]); end
      end
      m = first_mismatch(820);
      checks++;
      if (m !== -1) begin errors++; $display("FAIL back_to_back waveform at edge %0d got %b want %b", m, tx_log[m], ~tx_log[m]); end
      checks++;
      if (busy_log[800] !== 1'b1 || busy_log[801] !== 1'b0 || cnt_log[801] !== 3'd0)
         begin errors++; $display("FAIL back_to_back end busy %b%b count %0d want 10 0", busy_log[800], busy_log[801], cnt_log[801]); end
   endtask

   task automatic test_reset_mid_frame();
      int bad = 0;
      reset_all();
      baud_div = 16'd1;
      wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
      drive_and_watch(0, 3, 72);
      checks++;
      if (cnt_log[71] !== 3'd2 || tx_log[71] !== 1'b0)
         begin errors++; $display("FAIL pre_reset count %0d tx %b want 2 0", cnt_log[71], tx_log[71]); end
      rst = 1'b1;
      step();
      checks++;
      if (txl[0] !== 1'b1 || cnt[0] !== 3'd0 || ready[0] !== 1'b1 || busy[0] !== 1'b0)
         begin errors++; $display("FAIL mid_reset tx %b count %0d ready %b busy %b want 1 0 1 0", txl[0], cnt[0], ready[0], busy[0]); end
      rst = 1'b0;
      for (int c = 0; c < 300; c++) begin
         step();
         if (txl[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL post_reset_quiet got %0d active cycles want 0", bad); end
   endtask

   task automatic test_random();
      logic [7:0] exp_q [$];
      int bd;
      int per;
      bd  = $urandom_range(0, 2);
      per = 16 * ((bd == 0) ? 1 : bd);
      reset_all();
      baud_div = 16'(bd);
      fork
         begin : driver
            for (int n = 0; n < 10; n++) begin
               repeat ($urandom_range(0, 3)) step();
               valid[1] = 1'b1;
               din[1]   = 8'($urandom);
               for (int g = 0; g < 5000; g++) begin
                  if (ready[1] === 1'b1) begin
                     exp_q.push_back(din[1]);
                     step();
                     break;
                  end
                  step();
               end
               valid[1] = 1'b0;
            end
         end
         begin : monitor
            for (int f = 0; f < 10; f++) begin
               logic [7:0] got;
               logic       st, pb, sp;
               int         g = 0;
               while (txl[1] !== 1'b0 && g < 20000) begin step(); g++; end
               if (g >= 20000) begin
                  checks++; errors++;
                  $display("FAIL random_start_timeout frame %0d got none want start", f);
                  break;
               end
               repeat (per / 2) step();
               st = txl[1];
               for (int b = 0; b < 8; b++) begin repeat (per) step(); got[b] = txl[1]; end
               repeat (per) step(); pb = txl[1];
               repeat (per) step(); sp = txl[1];
               checks++;
               if (exp_q.size() == 0) begin
                  errors++; $display("FAIL random_frame %0d got %h want no frame", f, got);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  if (got !== e || st !== 1'b0 || pb !== ^e || sp !== 1'b1) begin
                     errors++;
                     $display("FAIL random_frame %0d got %h s%b p%b t%b want %h s0 p%b t1", f, got, st, pb, sp, e, ^e);
                  end
               end
            end
         end
      join
      begin
         int g = 0;
         while (busy[1] !== 1'b0 && g < 2000) begin step(); g++; end
         checks++;
         if (busy[1] !== 1'b0 || exp_q.size() != 0)
            begin errors++; $display("FAIL random_drain busy %b left %0d want 0 0", busy[1], exp_q.size()); end
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) din[i] = '0;
      test_reset();
      test_8n1(16'd1, "8n1_55");
      test_8n1(16'd0, "baud_zero");
      test_parity(1, 1, 1'b0, "8e1_a3");
      test_parity(2, 2, 1'b1, "8o1_a3");
      test_7n2();
      test_fifo_full();
      test_reset_mid_frame();
      test_random();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1, 2.
REQ-003 Parameter PARITY, default PARITY_NONE, parity mode; one of PARITY_NONE / PARITY_EVEN / PARITY_ODD.
REQ-004 Parameter OVERSAMPLE, default 16, baud ticks per bit.
REQ-005 Parameter DEPTH, default 4, transmit FIFO depth in words; power of two, at least 2.
REQ-006 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 Port rst, input, 1, reset; synchronous and active-high.
REQ-008 Port baud_div, input, 16, clk cycles per baud tick; 0 is treated as 1.
REQ-009 Port valid_in, input, 1, data_in valid.
REQ-010 Port data_in, input, DATA_BITS, word to transmit.
REQ-011 Port ready_out, output, 1, FIFO can accept a word (not full).
REQ-012 Port tx, output, 1, serial line, registered, idle high.
REQ-013 Port busy, output, 1, frame in progress or FIFO non-empty.
REQ-014 Port fifo_count, output, $clog2(DEPTH+1), words currently held in the FIFO.

Function
REQ-015 Accept: a word is written when valid_in and ready_out are both high at a rising edge; valid_in while ready_out is low is ignored and no state changes.
REQ-016 ready_out = (fifo_count != DEPTH), combinational from registered count.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY = PARITY_NONE.
REQ-018 IDLE -> START: when the FIFO is non-empty, pop one word into the shift register; the start bit appears on tx at the next edge.
REQ-019 Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE drives tx low from edge N+2.
REQ-020 Bit period = OVERSAMPLE x max(baud_div,1) clk cycles, exact for every bit.
REQ-021 The tick counter restarts at entry to START, so the start bit is never shortened.
REQ-022 DATA: send LSB first, DATA_BITS bits.
REQ-023 PARITY: even mode sends the XOR of all data bits; odd mode sends its inverse.
REQ-024 STOP: hold tx high for STOP_BITS bit periods.
REQ-025 End of STOP: if the FIFO is non-empty, pop and enter START on the same edge, leaving zero idle gap; otherwise go to IDLE.
REQ-026 Simultaneous push and pop: fifo_count is unchanged; when full, the push is refused per REQ-015 even in a cycle that pops.
REQ-027 baud_div changes mid-frame take effect at the next tick boundary; there are no glitches on tx.
REQ-028 busy = (state != IDLE) or (fifo_count != 0).

Reset
REQ-029 While rst is high at an edge: state = IDLE, tx = 1, fifo_count = 0, FIFO pointers = 0, ready_out = 1, busy = 0, tick and bit counters = 0.
REQ-030 Reset mid-frame aborts the frame; tx returns high at that edge and FIFO contents are discarded.

Structure
REQ-031 Package uart_pkg holds the parity_t enum (PARITY_NONE, PARITY_EVEN, PARITY_ODD) and the tx FSM state enum.
REQ-032 The FIFO is a sub-module uart_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, count), reusable by a future receiver.
REQ-033 Baud tick generation, the FSM and the shift register live in uart_tx_buffered.

Verification
REQ-034 8N1, baud_div=1, send 0x55 -> tx bits 0,1,0,1,0,1,0,1,0,1, each 16 clk cycles; tx low at accept edge + 2.
REQ-035 8E1 send 0xA3 -> parity bit 0; 8O1 send 0xA3 -> parity bit 1; frame length 11 bit periods.
REQ-036 DEPTH=4, six consecutive valid_in cycles with words 0x01..0x06 -> words 1-5 accepted, ready_out low from the 6th cycle, frames emitted 0x01..0x05 in order with no idle cycle between stop and start bits.
REQ-037 baud_div=3, 7N2, send 0x7F -> each bit 48 clk cycles; frame length 480 clk cycles; busy falls the cycle after the second stop bit ends.
REQ-038 rst asserted during data bit 3 with two words queued -> at that edge tx=1, fifo_count=0, ready_out=1, busy=0; no further frames.
REQ-039 baud_div=0 -> behaviour identical to baud_div=1 (16 clk cycles per bit).
